trng_arbiter: RTL and testbench
===============================

TRNG_ARBITER -- requirements
Module: trng_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the maximum cycles to wait for trng_rdy (16-bit counter).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 req  input  NREQ  level request per requester, held until that requester's ack.
REQ-006 ack  output  NREQ  one-hot, one-cycle completion pulse to the served requester.
REQ-007 rdata  output  64  random sample, valid only in the ack cycle.
REQ-008 err  output  1  high with ack when the transaction timed out; rdata SHALL then be 0.
REQ-009 trng_en  output  1  enable to the TRNG core.
REQ-010 trng_rd_en  output  1  read strobe to the TRNG core.
REQ-011 trng_addr  output  1  word select; 0 = low 32 bits, 1 = high 32 bits.
REQ-012 trng_out  input  32  TRNG read data, valid the cycle after trng_rd_en.
REQ-013 trng_rdy  input  1  TRNG sample ready.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT_RDY, RD_LO, RD_HI, CAP, and DONE.
REQ-015 IDLE: when req is nonzero, select idx by round-robin starting at pointer ptr, latch idx, clear the timer, and go to WAIT_RDY.
REQ-016 WAIT_RDY: trng_en=1 and the timer increments; trng_rdy=1 SHALL take priority and go to RD_LO; else timer==TIMEOUT-1 SHALL set the error flag and go to DONE.
REQ-017 RD_LO: trng_en=0, trng_rd_en=1, trng_addr=0 for exactly one cycle, then go to RD_HI.
REQ-018 RD_HI: trng_rd_en=1, trng_addr=1, capture trng_out into rdata[31:0], then go to CAP.
REQ-019 CAP: trng_rd_en=0, capture trng_out into rdata[63:32], then go to DONE.
REQ-020 DONE: ack[idx]=1 for one cycle, with rdata and err driven.
REQ-021 DONE SHALL set ptr to (idx+1) mod NREQ and return to IDLE.
REQ-022 Latency SHALL be ack exactly 4 cycles after the cycle trng_rdy is first sampled high in WAIT_RDY.
REQ-023 Minimum latency from req to ack SHALL be 5 cycles.
REQ-024 In every state other than the one stated, trng_en, trng_rd_en and trng_addr SHALL be 0.
REQ-025 Outside DONE, ack and err SHALL be 0 and rdata SHALL be 0.
REQ-026 Round-robin: the first set bit of req at or after ptr, wrapping from NREQ-1 to 0, SHALL be selected.
REQ-027 A requester whose req drops after grant SHALL still receive its ack; the transaction SHALL NOT be aborted.
REQ-028 req changes during a transaction SHALL be ignored until the FSM returns to IDLE.
REQ-029 A requester re-asserting req in the DONE cycle SHALL be considered in the next IDLE cycle after higher-priority requesters.
REQ-030 At most one ack bit SHALL ever be high.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, ptr=0, idx=0, timer=0, and all outputs 0, including mid-transaction.
REQ-032 After rst_n rises, the first grant SHALL follow REQ-026 from ptr=0.

Verification
REQ-033 req=4'b0001, trng_rdy high 3 cycles after trng_en, trng_out=32'hA5A5A5A5 then 32'h5A5A5A5A -> ack=4'b0001 with rdata=64'h5A5A5A5A_A5A5A5A5, err=0.
REQ-034 req=4'b1111 held for 4 transactions -> ack order 0001, 0010, 0100, 1000, then 0001.
REQ-035 ptr=3, req=4'b0101 -> ack=4'b0001 first, then 4'b0100.
REQ-036 trng_rdy held 0, TIMEOUT=16 -> trng_en high for 16 cycles, then ack with err=1, rdata=0.
REQ-037 rst_n pulsed low during RD_HI -> outputs 0 asynchronously, no ack, state IDLE; the next request is served normally.
REQ-038 req[2] dropped in RD_LO -> ack=4'b0100 still pulses; trng_rd_en is never high two cycles past CAP.

Source files
------------

// File: rtl/trng_arbiter.sv
// Round-robin arbiter that serves one requester at a time with a 64-bit sample
// read from a 32-bit TRNG core as two words, with a ready timeout.
module trng_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [63:0]     rdata,
    output logic            err,
    output logic            trng_en,
    output logic            trng_rd_en,
    output logic            trng_addr,
    input  logic [31:0]     trng_out,
    input  logic            trng_rdy,
    output logic [2:0]      state_o
);

    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        RD_LO    = 3'd2,
        RD_HI    = 3'd3,
        CAP      = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [15:0]     timer_q;
    logic [31:0]     lo_q;
    logic [IW-1:0]   grant_d;
    logic [IW-1:0]   ptr_d;
    logic [NREQ-1:0] onehot_d;

    // First set request bit at or after ptr, wrapping; the descending loop lets
    // the smallest offset from ptr win.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] pick;
        int unsigned   k;
        pick = p;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(p) + i) % NREQ;
            if (r[k]) pick = IW'(k);
        end
        return pick;
    endfunction

    assign grant_d  = rr_pick(req, ptr_q);
    assign ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    assign onehot_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign state_o  = state_q;

    // Outputs are registered: each branch loads the values belonging to the
    // state being entered, so they line up with state_q in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            lo_q       <= '0;
            ack        <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            trng_en    <= 1'b0;
            trng_rd_en <= 1'b0;
            trng_addr  <= 1'b0;
        end else begin
            ack        <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            trng_en    <= 1'b0;
            trng_rd_en <= 1'b0;
            trng_addr  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        idx_q   <= grant_d;
                        timer_q <= '0;
                        trng_en <= 1'b1;
                        state_q <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    timer_q <= timer_q + 16'd1;
                    if (trng_rdy) begin
                        trng_rd_en <= 1'b1;
                        state_q    <= RD_LO;
                    end else if (timer_q == TMO_LAST) begin
                        ack     <= onehot_d;
                        err     <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        trng_en <= 1'b1;
                    end
                end
                RD_LO: begin
                    trng_rd_en <= 1'b1;
                    trng_addr  <= 1'b1;
                    state_q    <= RD_HI;
                end
                RD_HI: begin
                    // Low word requested in RD_LO is on trng_out this cycle.
                    lo_q    <= trng_out;
                    state_q <= CAP;
                end
                CAP: begin
                    ack     <= onehot_d;
                    rdata   <= {trng_out, lo_q};
                    state_q <= DONE;
                end
                DONE: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// Directed and randomized bench for trng_arbiter: a behavioural TRNG responder
// plus a round-robin / latency reference model checked with immediate asserts.
module tb_trng_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [63:0] rdata;
    logic        err;
    logic        trng_en;
    logic        trng_rd_en;
    logic        trng_addr;
    logic [31:0] trng_out;
    logic        trng_rdy;
    logic [2:0]  state_dbg;

    int          n_vec;
    int          n_err;
    int          ptr_m;
    logic [31:0] lo_w;
    logic [31:0] hi_w;
    logic [3:0]  ack_obs;

    trng_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .trng_en    (trng_en),
        .trng_rd_en (trng_rd_en),
        .trng_addr  (trng_addr),
        .trng_out   (trng_out),
        .trng_rdy   (trng_rdy),
        .state_o    (state_dbg)
    );

    always #5 clk = ~clk;

    // TRNG core: the word selected by trng_addr appears the cycle after the strobe.
    always @(posedge clk) begin
        trng_out <= trng_rd_en ? (trng_addr ? hi_w : lo_w) : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int off = 0; off < NREQ; off++) begin
            if (r[(p + off) % NREQ]) return (p + off) % NREQ;
        end
        return 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_en"}, trng_en, 0);
        chk({tag, "_rd_en"}, trng_rd_en, 0);
        chk({tag, "_addr"}, trng_addr, 0);
    endtask

    // Called at a negedge while the DUT is (or is about to be) in IDLE with req set.
    // mode 0: normal, 1: granted requester drops req in RD_LO, 2: reset in RD_HI.
    task automatic txn(input int d, input int mode, input bit keep,
                       input logic [31:0] lo, input logic [31:0] hi,
                       output logic [3:0] seen);
        int         g, en_cnt, last_en, rd_cnt;
        bit         done, tmo;
        logic [3:0] exp_ack;
        lo_w = lo;
        hi_w = hi;
        g = rr_model(req, ptr_m);
        exp_ack = 4'b0001 << g;
        en_cnt = 0; last_en = 0; rd_cnt = 0; done = 0; seen = '0;
        tmo = (d + 1) > TIMEOUT;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (ack == 4'b0000) begin
                chk("rdata_outside_done", rdata, 0);
                chk("err_outside_done", err, 0);
            end
            chk("en_rd_overlap", trng_en & trng_rd_en, 0);
            if (trng_en) begin
                en_cnt++;
                last_en = cyc;
            end
            trng_rdy = (trng_en === 1'b1) && (en_cnt > d);
            if (trng_rd_en) begin
                chk("rd_addr_order", trng_addr, rd_cnt);
                rd_cnt++;
                if (mode == 1 && !trng_addr) req[g] = 1'b0;
                if (mode == 2 && trng_addr) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("async_rst");
                    trng_rdy = 1'b0;
                    req = '0;
                    ptr_m = 0;
                    @(negedge clk);
                    chk_all_zero("held_rst");
                    rst_n = 1'b1;
                    return;
                end
            end
            if (ack != 4'b0000) begin
                done = 1;
                seen = ack;
                chk("ack_onehot", ack, exp_ack);
                chk("err_flag", err, tmo);
                chk("rdata", rdata, tmo ? 64'd0 : {hi, lo});
                chk("en_cycles", en_cnt, tmo ? TIMEOUT : d + 1);
                chk("rd_cycles", rd_cnt, tmo ? 0 : 2);
                chk("rdy_to_ack", cyc - last_en, tmo ? 1 : 4);
                chk("req_to_ack", cyc, tmo ? TIMEOUT + 1 : d + 5);
                ptr_m = (g + 1) % NREQ;
                if (!keep) req[g] = 1'b0;
                trng_rdy = 1'b0;
            end
        end
        chk("ack_seen", done, 1);
        @(negedge clk);
        chk("post_done_ack", ack, 0);
        chk("post_done_rd_en", trng_rd_en, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_order [5];
        n_vec = 0; n_err = 0; ptr_m = 0;
        rst_n = 1'b0; req = '0; trng_rdy = 1'b0; lo_w = '0; hi_w = '0;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_no_req");

        // All four requesters held: strict rotation from ptr 0, wrapping.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            txn($urandom_range(0, 4), 0, 1, $urandom, $urandom, ack_obs);
            chk("rr_order", ack_obs, exp_order[i]);
        end

        req = 4'b0001;
        txn(3, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, ack_obs);
        chk("fixed_sample_ack", ack_obs, 4'b0001);

        req = 4'b0010;
        txn(0, 0, 0, $urandom, $urandom, ack_obs);
        chk("min_latency_ack", ack_obs, 4'b0010);

        // Move ptr to 3, then two requesters below it.
        req = 4'b0100;
        txn(1, 0, 0, $urandom, $urandom, ack_obs);
        req = 4'b0101;
        txn(2, 0, 0, $urandom, $urandom, ack_obs);
        chk("wrap_first", ack_obs, 4'b0001);
        txn(0, 0, 0, $urandom, $urandom, ack_obs);
        chk("wrap_second", ack_obs, 4'b0100);

        req = 4'b1000;
        txn(1000, 0, 0, $urandom, $urandom, ack_obs);
        chk("timeout_ack", ack_obs, 4'b1000);

        req = 4'b0100;
        txn(2, 1, 0, $urandom, $urandom, ack_obs);
        chk("dropped_req_ack", ack_obs, 4'b0100);

        req = 4'b0010;
        txn(1, 2, 0, $urandom, $urandom, ack_obs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_ack", ack, 0);
            chk("after_rst_en", trng_en, 0);
        end
        req = 4'b1010;
        txn(2, 0, 0, $urandom, $urandom, ack_obs);
        chk("after_rst_grant", ack_obs, 4'b0010);
        req = '0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0000) req = 4'($urandom_range(1, 15));
            txn($urandom_range(0, 20), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                $urandom, $urandom, ack_obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
